// File: rtl/gray_step_ctrl.sv
// Command-driven Gray-code counter: CLEAR / LOAD / RUN-N-steps (up or down) over valid/ready,
// with registered done, aborted and wrap pulses.
module gray_step_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clock,
  input  logic             Reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_arg,
  input  logic             stop,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] One  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MaxG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] remaining_q;
  logic             dir_q;

  logic [WIDTH-1:0] q_bin;
  logic [WIDTH-1:0] next_bin;
  logic [WIDTH-1:0] next_gray;
  logic             wrap_cond;

  // Binary bit i is the XOR of Gray bits i and above.
  always_comb begin
    q_bin = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      q_bin[i] = ^(q >> i);
    end
    next_bin  = dir_q ? (q_bin + One) : (q_bin - One);
    next_gray = next_bin ^ (next_bin >> 1);
    wrap_cond = dir_q ? (q == MaxG) : (q == '0);
  end

  assign cmd_ready = (state_q == StIdle);

  always_ff @(posedge clock) begin
    if (!Reset) begin
      state_q     <= StIdle;
      q           <= '0;
      remaining_q <= '0;
      dir_q       <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
      wrap        <= 1'b0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      wrap    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            unique case (cmd_op)
              2'b00: begin
                q    <= '0;
                done <= 1'b1;
              end
              2'b01: begin
                q    <= cmd_arg;
                done <= 1'b1;
              end
              2'b10, 2'b11: begin
                if (cmd_arg == '0) begin
                  done <= 1'b1;
                end else begin
                  remaining_q <= cmd_arg;
                  dir_q       <= (cmd_op == 2'b10);
                  state_q     <= StRun;
                  busy        <= 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
        StRun: begin
          // stop wins even over the final step
          if (stop) begin
            aborted <= 1'b1;
            state_q <= StIdle;
            busy    <= 1'b0;
          end else begin
            q           <= next_gray;
            wrap        <= wrap_cond;
            remaining_q <= remaining_q - One;
            if (remaining_q == One) begin
              done    <= 1'b1;
              state_q <= StIdle;
              busy    <= 1'b0;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
